// File: rtl/mac.sv
// mac: registered unsigned multiply-accumulate, y accumulates the previously registered product
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, clears m and y
//   x1,x2 : XW-bit unsigned operands
//   m     : OW-bit registered product (truncated, or clamped with MAC_SAT_EN)
//   y     : OW-bit registered accumulator (wraps, or clamps with MAC_SAT_EN)
//   Define MAC_SAT_EN for saturating arithmetic; the default build wraps.
module mac #(
   parameter int XW = 8,
   parameter int OW = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [XW-1:0] x1,
   input  logic [XW-1:0] x2,
   output logic [OW-1:0] m,
   output logic [OW-1:0] y
);
   logic [2*XW-1:0] p;
   logic [OW:0]     s;
   logic [OW-1:0]   m_d;
   logic [OW-1:0]   y_d;
   assign p = {{XW{1'b0}}, x1} * {{XW{1'b0}}, x2};
   assign s = {1'b0, y} + {1'b0, m};
`ifdef MAC_SAT_EN
   // any product bit above OW or a carry out of the sum means overflow
   assign m_d = |p[2*XW-1:OW] ? '1 : p[OW-1:0];
   assign y_d = s[OW] ? '1 : s[OW-1:0];
`else
   assign m_d = p[OW-1:0];
   assign y_d = s[OW-1:0];
`endif
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         m <= '0;
         y <= '0;
      end else begin
         m <= m_d;
         y <= y_d;
      end
endmodule

// File: tb/tb_mac.sv
// tb_mac: directed self-checking bench for mac (expectations follow MAC_SAT_EN when defined)
module tb_mac;
   logic       clk = 0;
   logic       reset = 0;
   logic [7:0] x1 = 0;
   logic [7:0] x2 = 0;
   logic [9:0] m;
   logic [9:0] y;
   int         passed = 0;
   int         total = 0;

   mac #(.XW(8), .OW(10)) dut (.clk(clk), .reset(reset), .x1(x1), .x2(x2), .m(m), .y(y));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

`ifdef MAC_SAT_EN
   localparam logic [9:0] Y17 = 10'd1023, Y18 = 10'd1023, M255 = 10'd1023, M1024 = 10'd1023;
`else
   localparam logic [9:0] Y17 = 10'd0, Y18 = 10'd64, M255 = 10'd513, M1024 = 10'd0;
`endif

   initial begin
      // reset held: outputs stay zero while inputs toggle
      for (int i = 0; i < 4; i++) begin
         x1 = 8'(17 * (i + 1));
         x2 = 8'(200 - i);
         tick();
         chk("rst_m", m, 10'd0);
         chk("rst_y", y, 10'd0);
      end
      // accumulate 64 per cycle
      @(negedge clk);
      x1 = 32;
      x2 = 2;
      reset = 1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk($sformatf("acc_m%0d", k), m, 10'd64);
         chk($sformatf("acc_y%0d", k), y, 10'(64 * (k - 1)));
      end
      tick();
      chk("edge17_y", y, Y17);
      tick();
      chk("edge18_y", y, Y18);
      for (int k = 19; k <= 21; k++) begin
         tick();
`ifdef MAC_SAT_EN
         chk($sformatf("sat_hold_y%0d", k), y, 10'd1023);
`else
         chk($sformatf("wrap_y%0d", k), y, 10'(64 * (k - 17)));
`endif
      end
      // product patterns
      x1 = 255; x2 = 255; tick(); chk("m_255x255", m, M255);
      x1 = 3;   x2 = 5;   tick(); chk("m_3x5", m, 10'd15);
      x1 = 0;   x2 = 77;  tick(); chk("m_0x77", m, 10'd0);
      x1 = 100; x2 = 10;  tick(); chk("m_100x10", m, 10'd1000);
      x1 = 128; x2 = 8;   tick(); chk("m_128x8", m, M1024);
      x1 = 31;  x2 = 33;  tick(); chk("m_31x33", m, 10'd1023);
      // mid-run async reset after fresh accumulation
      reset = 0;
      #1;
      reset = 1;
      x1 = 4; x2 = 5;
      tick(); tick(); tick();
      chk("pre_async_y", y, 10'd40);
      #2;
      reset = 0;
      #1;
      chk("async_m", m, 10'd0);
      chk("async_y", y, 10'd0);
      @(negedge clk);
      x1 = 7; x2 = 9;
      reset = 1;
      tick(); chk("rel_m1", m, 10'd63); chk("rel_y1", y, 10'd0);
      tick(); chk("rel_y2", y, 10'd63);
      tick(); chk("rel_y3", y, 10'd126);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
